// File: rtl/line_drawer_if.sv
// Handshake/data bundle between the line-drawing controller, the Bresenham
// engine and the pixel writer.
interface line_drawer_if #(
    parameter int X_WIDTH      = 9,
    parameter int Y_WIDTH      = 8,
    parameter int COLOUR_WIDTH = 3
);
    logic                    i_go;
    logic [COLOUR_WIDTH-1:0] i_colour;
    logic [X_WIDTH-1:0]      i_X0;
    logic [Y_WIDTH-1:0]      i_Y0;
    logic [X_WIDTH-1:0]      i_X1;
    logic [Y_WIDTH-1:0]      i_Y1;
    logic                    i_pixel_ready;
    logic                    o_plot;
    logic [X_WIDTH-1:0]      o_x;
    logic [Y_WIDTH-1:0]      o_y;
    logic [COLOUR_WIDTH-1:0] o_colour;
    logic                    o_done;

    modport master (
        output i_go, i_colour, i_X0, i_Y0, i_X1, i_Y1, i_pixel_ready,
        input  o_plot, o_x, o_y, o_colour, o_done
    );

    modport slave (
        input  i_go, i_colour, i_X0, i_Y0, i_X1, i_Y1, i_pixel_ready,
        output o_plot, o_x, o_y, o_colour, o_done
    );
endinterface

// File: rtl/line_drawer.sv
// Bresenham line engine: latches endpoints on go, emits one pixel per
// accepted cycle and holds a level done until go is released.
module line_drawer #(
    parameter int X_WIDTH      = 9,
    parameter int Y_WIDTH      = 8,
    parameter int COLOUR_WIDTH = 3
) (
    input  logic          clock,
    input  logic          i_reset_n,
    line_drawer_if.slave  bus
);
    localparam int CW = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 1;
    localparam int EW = CW + 1;
    localparam logic signed [CW-1:0] C_ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;
    state_t state, state_next;

    logic [X_WIDTH-1:0]      x0_l, x1_l;
    logic [Y_WIDTH-1:0]      y0_l, y1_l;
    logic [COLOUR_WIDTH-1:0] colour_l;
    logic signed [CW-1:0]    x, y, x_end, dx, dy;
    logic signed [EW-1:0]    err;
    logic                    steep, ystep_neg;

    logic signed [CW-1:0] px0, py0, px1, py1, adx, ady;
    logic signed [CW-1:0] ax0, ay0, ax1, ay1, bx0, by0, bx1, by1, init_dx;
    logic                 init_steep;
    logic signed [EW-1:0] dx_w, dy_w, err_inc;
    logic signed [CW-1:0] out_x, out_y;
    logic                 drawing;

    // Octant normalisation: make the major axis x and the walk left-to-right
    always_comb begin
        px0 = $signed(CW'(x0_l));
        py0 = $signed(CW'(y0_l));
        px1 = $signed(CW'(x1_l));
        py1 = $signed(CW'(y1_l));
        adx = (px1 >= px0) ? px1 - px0 : px0 - px1;
        ady = (py1 >= py0) ? py1 - py0 : py0 - py1;
        init_steep = (ady > adx);
        ax0 = init_steep ? py0 : px0;
        ay0 = init_steep ? px0 : py0;
        ax1 = init_steep ? py1 : px1;
        ay1 = init_steep ? px1 : py1;
        if (ax0 > ax1) begin
            bx0 = ax1; by0 = ay1; bx1 = ax0; by1 = ay0;
        end else begin
            bx0 = ax0; by0 = ay0; bx1 = ax1; by1 = ay1;
        end
        init_dx = bx1 - bx0;
    end

    always_comb begin
        dx_w    = EW'(dx);
        dy_w    = EW'(dy);
        err_inc = err + dy_w;
    end

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.i_go) state_next = INIT;
            INIT: state_next = DRAW;
            DRAW: if (bus.i_pixel_ready && (x == x_end)) state_next = DONE;
            DONE: if (!bus.i_go) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            x0_l      <= '0;
            y0_l      <= '0;
            x1_l      <= '0;
            y1_l      <= '0;
            colour_l  <= '0;
            x         <= '0;
            y         <= '0;
            x_end     <= '0;
            dx        <= '0;
            dy        <= '0;
            err       <= '0;
            steep     <= 1'b0;
            ystep_neg <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.i_go) begin
                    x0_l     <= bus.i_X0;
                    y0_l     <= bus.i_Y0;
                    x1_l     <= bus.i_X1;
                    y1_l     <= bus.i_Y1;
                    colour_l <= bus.i_colour;
                end
                INIT: begin
                    x         <= bx0;
                    y         <= by0;
                    x_end     <= bx1;
                    dx        <= init_dx;
                    dy        <= (by1 >= by0) ? by1 - by0 : by0 - by1;
                    ystep_neg <= !(by0 < by1);
                    steep     <= init_steep;
                    err       <= -(EW'(init_dx) >>> 1);
                end
                DRAW: if (bus.i_pixel_ready && (x != x_end)) begin
                    x <= x + C_ONE;
                    if (!err_inc[EW-1]) begin
                        y   <= ystep_neg ? y - C_ONE : y + C_ONE;
                        err <= err_inc - dx_w;
                    end else begin
                        err <= err_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset drops them at once
    always_comb begin
        drawing      = (state == DRAW);
        out_x        = steep ? y : x;
        out_y        = steep ? x : y;
        bus.o_plot   = drawing;
        bus.o_done   = (state == DONE);
        bus.o_x      = drawing ? X_WIDTH'(out_x) : '0;
        bus.o_y      = drawing ? Y_WIDTH'(out_y) : '0;
        bus.o_colour = drawing ? colour_l : '0;
    end
endmodule

// File: tb/tb_line_drawer.sv
// Self-checking bench for line_drawer: directed lines plus randomized lines
// with random backpressure, compared against an integer Bresenham model.
module tb_line_drawer;
    logic clock;
    logic i_reset_n;
    int   errors = 0;
    int   checks = 0;
    int   exp_x[$];
    int   exp_y[$];

    line_drawer_if #(.X_WIDTH(9), .Y_WIDTH(8), .COLOUR_WIDTH(3)) bus ();

    line_drawer #(.X_WIDTH(9), .Y_WIDTH(8), .COLOUR_WIDTH(3)) dut (
        .clock     (clock),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic push_pt(input int px, input int py);
        exp_x.push_back(px);
        exp_y.push_back(py);
    endtask

    // Reference: textbook integer Bresenham producing the expected pixel list
    task automatic model_line(input int x0, input int y0, input int x1, input int y1);
        int t, dxm, dym, e, ys, cx, cy;
        bit st;
        st = iabs(y1 - y0) > iabs(x1 - x0);
        if (st) begin
            t = x0; x0 = y0; y0 = t;
            t = x1; x1 = y1; y1 = t;
        end
        if (x0 > x1) begin
            t = x0; x0 = x1; x1 = t;
            t = y0; y0 = y1; y1 = t;
        end
        dxm = x1 - x0;
        dym = iabs(y1 - y0);
        ys  = (y0 < y1) ? 1 : -1;
        e   = -(dxm / 2);
        cx  = x0;
        cy  = y0;
        forever begin
            if (st) push_pt(cy, cx);
            else    push_pt(cx, cy);
            if (cx == x1) break;
            cx++;
            e += dym;
            if (e >= 0) begin
                cy += ys;
                e  -= dxm;
            end
        end
    endtask

    // mode 0: always ready, 1: random stalls, 2: 3-cycle stall at the third pixel
    task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                            input int col, input int mode, input int hold);
        int  n0, acc, stalls, cyc, budget;
        logic rdy;
        n0     = exp_x.size();
        budget = n0 * 8 + 20;
        bus.i_X0          = 9'(x0);
        bus.i_Y0          = 8'(y0);
        bus.i_X1          = 9'(x1);
        bus.i_Y1          = 8'(y1);
        bus.i_colour      = 3'(col);
        bus.i_go          = 1'b1;
        bus.i_pixel_ready = 1'b1;
        @(posedge clock); #1;
        check("lat_init_plot", int'(bus.o_plot), 0);
        bus.i_X0     = 9'($urandom);
        bus.i_Y0     = 8'($urandom);
        bus.i_X1     = 9'($urandom);
        bus.i_Y1     = 8'($urandom);
        bus.i_colour = 3'($urandom);
        @(posedge clock); #1;
        check("lat_first_plot", int'(bus.o_plot), 1);
        acc = 0; stalls = 0; cyc = 0;
        while (exp_x.size() > 0 && cyc < budget) begin
            check("plot", int'(bus.o_plot), 1);
            check("x", int'(bus.o_x), exp_x[0]);
            check("y", int'(bus.o_y), exp_y[0]);
            check("colour", int'(bus.o_colour), col);
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    if (acc == 2 && stalls < 3) begin
                        rdy = 1'b0;
                        stalls++;
                    end else begin
                        rdy = 1'b1;
                    end
                end
            endcase
            bus.i_pixel_ready = rdy;
            @(posedge clock); #1;
            cyc++;
            if (rdy) begin
                void'(exp_x.pop_front());
                void'(exp_y.pop_front());
                acc++;
            end
        end
        check("pixels_left", exp_x.size(), 0);
        check("accepted", acc, n0);
        check("done_rise", int'(bus.o_done), 1);
        check("plot_after_last", int'(bus.o_plot), 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check("done_hold", int'(bus.o_done), 1);
            check("no_restart", int'(bus.o_plot), 0);
        end
        bus.i_go = 1'b0;
        @(posedge clock); #1;
        check("done_drop", int'(bus.o_done), 0);
        check("idle_plot", int'(bus.o_plot), 0);
        bus.i_pixel_ready = 1'b0;
    endtask

    initial begin
        int rx0, ry0, rx1, ry1;
        i_reset_n         = 1'b0;
        bus.i_go          = 1'b0;
        bus.i_colour      = '0;
        bus.i_X0          = '0;
        bus.i_Y0          = '0;
        bus.i_X1          = '0;
        bus.i_Y1          = '0;
        bus.i_pixel_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_plot", int'(bus.o_plot), 0);
        check("rst_done", int'(bus.o_done), 0);
        check("rst_x", int'(bus.o_x), 0);
        check("rst_y", int'(bus.o_y), 0);
        check("rst_colour", int'(bus.o_colour), 0);
        i_reset_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i <= 4; i++) push_pt(i, 0);
        run_line(0, 0, 4, 0, 5, 0, 2);

        push_pt(0, 0); push_pt(1, 1); push_pt(1, 2);
        push_pt(1, 3); push_pt(2, 4); push_pt(2, 5);
        run_line(0, 0, 2, 5, 3, 0, 1);

        for (int i = 0; i <= 4; i++) push_pt(i, 2);
        run_line(4, 2, 0, 2, 6, 0, 0);

        push_pt(7, 7);
        run_line(7, 7, 7, 7, 1, 0, 10);

        model_line(0, 0, 5, 3);
        run_line(0, 0, 5, 3, 2, 2, 1);

        // Reset in the middle of a long line
        bus.i_X0 = 9'd0; bus.i_Y0 = 8'd0; bus.i_X1 = 9'd100; bus.i_Y1 = 8'd50;
        bus.i_colour = 3'd7; bus.i_go = 1'b1; bus.i_pixel_ready = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("mid_plot", int'(bus.o_plot), 1);
        #2 i_reset_n = 1'b0;
        #1;
        check("async_rst_plot", int'(bus.o_plot), 0);
        check("async_rst_done", int'(bus.o_done), 0);
        check("async_rst_x", int'(bus.o_x), 0);
        bus.i_go = 1'b0;
        bus.i_pixel_ready = 1'b0;
        @(posedge clock); #1;
        check("rst_held_plot", int'(bus.o_plot), 0);
        i_reset_n = 1'b1;
        @(posedge clock); #1;
        model_line(30, 200, 10, 190);
        run_line(30, 200, 10, 190, 4, 1, 1);

        model_line(0, 0, 511, 255);
        run_line(0, 0, 511, 255, 5, 0, 0);
        model_line(511, 255, 0, 0);
        run_line(511, 255, 0, 0, 2, 1, 0);
        model_line(400, 10, 400, 200);
        run_line(400, 10, 400, 200, 1, 1, 0);
        model_line(0, 255, 300, 0);
        run_line(0, 255, 300, 0, 6, 1, 1);

        for (int n = 0; n < 30; n++) begin
            int col;
            rx0 = $urandom_range(0, 511);
            ry0 = $urandom_range(0, 255);
            if (n % 3 == 0) begin
                rx1 = $urandom_range(0, 511);
                ry1 = $urandom_range(0, 255);
            end else begin
                rx1 = (rx0 + $urandom_range(0, 40)) % 512;
                ry1 = (ry0 + $urandom_range(0, 40)) % 256;
            end
            col = $urandom_range(0, 7);
            model_line(rx0, ry0, rx1, ry1);
            run_line(rx0, ry0, rx1, ry1, col, 1, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
